// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state encoding for the BCD/binary conversion blocks
//
// Contents:
//   DEFAULT_DIGITS / DEFAULT_WIDTH : operand size shared with the binary-to-BCD display path
//   BCD_MAX_DIGIT                  : largest legal BCD nibble value
//   state_t                        : converter FSM state encoding
package bcd_pkg;

    localparam int DEFAULT_DIGITS = 9;
    localparam int DEFAULT_WIDTH  = 30;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - request/result bundle for the sequential BCD-to-binary converter
//
// Signals:
//   start   : conversion request (requester -> converter)
//   bcd_in  : packed BCD operand, digit 0 at [3:0] (requester -> converter)
//   busy    : conversion in progress (converter -> requester)
//   done    : one-cycle completion pulse (converter -> requester)
//   err     : operand held a nibble > 9, valid from done (converter -> requester)
//   bin_out : binary result, held until the next good conversion (converter -> requester)
interface bcd_to_binary_seq_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int WIDTH  = DEFAULT_WIDTH
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [WIDTH-1:0]      bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output err,
        output bin_out
    );

endinterface

// File: rtl/bcd_nibble_adj.sv
// rtl/bcd_nibble_adj.sv - reverse double-dabble correction for one BCD nibble
//
// Ports:
//   nib_i : nibble after the right shift
//   nib_o : nib_i - 3 when nib_i >= 8, otherwise nib_i
module bcd_nibble_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // A nibble >= 8 after a right shift means a 10 moved down as 8 instead of 5.
    assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - iterative reverse double-dabble BCD-to-binary converter
//
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of bcd_to_binary_seq_if (start/bcd_in in, busy/done/err/bin_out out)
//
// A good operand takes WIDTH shift cycles plus one FINISH cycle; an operand with a
// nibble > 9 skips straight to FINISH and leaves bin_out untouched.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    bcd_to_binary_seq_if.slave   bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  bin_out_q, bin_out_d;

    logic [DIGITS-1:0]   dig_bad;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       bcd_adj;

    // The BCD LSB falls into the binary MSB on every shift.
    assign shifted = {bcd_q, bin_q} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign dig_bad[g] = (bus.bcd_in[4*g +: 4] > BCD_MAX_DIGIT);

        bcd_nibble_adj u_adj (
            .nib_i (shifted[WIDTH + 4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bin_out_q <= bin_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bin_out_d = bin_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (|dig_bad) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        bcd_d   = bus.bcd_in;
                        bin_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        err_d   = 1'b0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (!err_q) begin
                    bin_out_d = bin_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

    localparam int DIGITS = 9;
    localparam int WIDTH  = 30;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [63:0] exp_bin      = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal value of the operand read digit by digit, most significant first.
    function automatic void model(input logic [35:0] b, output bit bad, output longint val);
        logic [3:0] d;
        bad = 1'b0;
        val = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            val = val * 10 + longint'(d);
        end
    endfunction

    function automatic logic [35:0] rand_bcd(input bit make_bad);
        logic [35:0] b;
        for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
        if (make_bad) b[4*$urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
        return b;
    endfunction

    // One conversion. restart_at > 0 pulses start with a different operand at that
    // cycle; hold_start leaves start high and the operand stable to the end.
    task automatic run(input string tag, input logic [35:0] bcd, input int restart_at,
                       input bit hold_start);
        bit          bad;
        longint      val;
        int          lat;
        int          n;
        bit          got;
        logic [63:0] r;
        model(bcd, bad, val);
        lat = bad ? 2 : WIDTH + 2;
        @(negedge CLOCK_50);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        n   = 0;
        got = 1'b0;
        while (n < lat + 5 && !got) begin
            @(negedge CLOCK_50);
            n++;
            if (!hold_start) begin
                r          = {$urandom, $urandom};
                bus.bcd_in = r[35:0];
                bus.start  = (restart_at > 0 && n == restart_at);
            end
            if (bus.done) got = 1'b1;
            else if (n < lat) check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        end
        if (!bad) exp_bin = 64'(val);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'(bad));
        check({tag, "_bin"}, 64'(bus.bin_out), exp_bin);
        if (!hold_start) begin
            bus.start = 1'b0;
            @(negedge CLOCK_50);
            check({tag, "_done_width"}, 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        int n;
        bit got;
        bus.start  = 1'b0;
        bus.bcd_in = '0;

        // reset state
        repeat (3) @(negedge CLOCK_50);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_bin", 64'(bus.bin_out), 64'd0);
        reset_n = 1'b1;

        // directed operands
        run("zero", 36'h000000000, 0, 1'b0);
        run("seq", 36'h123456789, 0, 1'b0);
        check("seq_const", 64'(bus.bin_out), 64'h075BCD15);
        run("max", 36'h999999999, 0, 1'b0);
        check("max_const", 64'(bus.bin_out), 64'h3B9AC9FF);
        run("bad", 36'h1234A6789, 0, 1'b0);
        check("bad_keep", 64'(bus.bin_out), 64'h3B9AC9FF);

        // start during a conversion is ignored
        run("restart", 36'h123456789, 10, 1'b0);
        check("restart_const", 64'(bus.bin_out), 64'h075BCD15);
        check("restart_err", 64'(bus.err), 64'd0);

        // held start re-triggers right after done
        run("hold", 36'h000000777, 0, 1'b1);
        @(negedge CLOCK_50);
        check("hold_retrig_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < WIDTH + 5 && !got) begin
            @(negedge CLOCK_50);
            n++;
            if (bus.done) got = 1'b1;
        end
        check("hold_retrig_done", 64'(got), 64'd1);
        check("hold_retrig_bin", 64'(bus.bin_out), 64'd777);

        // reset in the middle of a conversion
        @(negedge CLOCK_50);
        bus.start  = 1'b1;
        bus.bcd_in = 36'h555555555;
        repeat (15) begin
            @(negedge CLOCK_50);
            bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_bin", 64'(bus.bin_out), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        exp_bin = '0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        run("after_rst", 36'h000000042, 0, 1'b0);
        check("after_rst_const", 64'(bus.bin_out), 64'd42);

        // random operands, roughly one in five invalid
        for (int i = 0; i < 20; i++) begin
            run("rand", rand_bcd($urandom_range(0, 4) == 0), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD display path.
- Takes a packed DIGITS-digit BCD word, e.g. a value keyed in from switches/buttons or read back from the 7-seg digit registers.
- Produces the unsigned binary equivalent using iterative reverse double-dabble: shift right, then subtract 3 from any BCD nibble ≥ 8.
- Runs on CLOCK_50 with a start/busy/done handshake.
- Feeds loadable counters and compare registers in the counter/display datapath.

Parameters:
- DIGITS, 9: number of packed BCD digits on bcd_in. Digit 0 is the LSD at bits [3:0].
- WIDTH, 30: binary result width.
  - Must satisfy WIDTH ≥ ceil(DIGITS·log2 10). DIGITS=9 needs 30.
  - Also sets the iteration count.

Ports:
- CLOCK_50  in   1           system clock, 50 MHz, rising edge.
- reset_n   in   1           reset; asynchronous, active-low.
- start     in   1           conversion request, sampled on the rising edge.
- bcd_in    in   4*DIGITS    packed BCD operand, sampled only on an accepted start.
- busy      out  1           high while a conversion is in progress.
- done      out  1           one-cycle completion pulse.
- err       out  1           operand contained a nibble > 9; valid with done.
- bin_out   out  WIDTH       converted result; holds until the next successful conversion.

Behaviour:
- Reset state (asynchronous, on reset_n low):
  - state=IDLE; busy=0, done=0, err=0, bin_out=0.
  - Internal BCD shift register and binary shift register = 0; iteration counter = 0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - Start accepted on an edge where start=1 and state=IDLE.
  - If any nibble of bcd_in > 9:
    - go to FINISH with err latched to 1;
    - bin_out is not modified.
  - Otherwise:
    - load the BCD register with bcd_in and clear the binary register;
    - counter = WIDTH; err=0; go to SHIFT.
  - busy rises on the accepting edge.
- SHIFT, one iteration per clock:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1. The LSB of bcd_reg enters the MSB of bin_reg.
  - In the same edge, every shifted nibble ≥ 8 gets 3 subtracted (nibble-local, no borrow between nibbles).
  - Decrement counter. After the edge where counter reaches 0, go to FINISH.
- FINISH, exactly one cycle:
  - If no error: bin_out = bin_reg.
  - done=1, busy=0 at the next edge; then state=IDLE.
- done timing:
  - done is a registered pulse, exactly 1 cycle wide.
  - Valid conversion: start accepted at edge k → done high for cycle k+WIDTH+1.
  - Invalid operand: done high for cycle k+1 (error short-circuit).
- err: stays valid from the done pulse until the next accepted start.
- start while busy (SHIFT or FINISH): ignored, no queuing.
  - start held high continuously re-triggers on the first IDLE cycle after done.
- bcd_in changes during a conversion have no effect; the operand was captured at start.
- Arithmetic:
  - Everything is unsigned; no overflow is possible when the WIDTH rule holds.
  - Maximum value: 10^DIGITS − 1.
- Reset asserted mid-conversion: immediate return to the reset state, no done pulse, bin_out=0.

Decomposition:
- Shared package bcd_pkg:
  - state encoding constants S_IDLE=2'b00, S_SHIFT=2'b01, S_FINISH=2'b10;
  - BCD_MAX_DIGIT=4'd9;
  - default DIGITS/WIDTH, so they stay consistent with the binary-to-BCD block.
- Sub-module bcd_nibble_adj (combinational):
  - 4-bit in/out; out = in − 3 if in ≥ 8, else in.
  - Instantiated DIGITS times via generate.
- Digit validity check is a generate loop in the top module.

Test Plan:
- bcd_in=0x000000000, start pulse → done after 31 cycles, bin_out=0, err=0, busy high for cycles 1–30.
- bcd_in=0x123456789 → bin_out=30'h075BCD15, err=0.
- bcd_in=0x999999999 → bin_out=30'h3B9AC9FF, err=0.
- bcd_in=0x1234A6789 after a good conversion → done the next cycle, err=1, bin_out keeps its previous value.
- start=1 again at cycle 10 of a conversion with a new bcd_in → ignored; original result 30'h075BCD15 reported; single done pulse.
- reset_n low at cycle 15 of a conversion → busy=0, done=0, bin_out=0 immediately. A fresh start of 0x000000042 then yields bin_out=42.
